// File: rtl/pipibibs_rom_fetch.sv
// 68K program-ROM fetch adaptor: direct-mapped one-word-per-line cache in front of an
// SDRAM bank port, issuing one read handshake per miss plus an optional next-word prefetch.
module pipibibs_rom_fetch #(
  parameter int          ADDR_W      = 17,
  parameter int          LINES       = 8,
  parameter logic [21:0] BANK_OFFSET = 22'h000000,
  parameter bit          PREFETCH    = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              CPU_CS,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  output logic [15:0]       CPU_DOUT,
  output logic              CPU_OK,
  input  logic              INVALIDATE,
  output logic [21:0]       BA_ADDR,
  output logic              BA_RD,
  input  logic              BA_ACK,
  input  logic              BA_RDY,
  input  logic [15:0]       DATA_READ
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_PREQ  = 3'd3,
    ST_PWAIT = 3'd4
  } state_t;

  state_t            state_r;
  logic [LINES-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [15:0]       data_r [LINES];
  logic [ADDR_W-1:0] fetch_addr_r;

  logic [IDX_W-1:0]  cpu_idx_s;
  logic [IDX_W-1:0]  fill_idx_s;
  logic [IDX_W-1:0]  next_idx_s;
  logic [ADDR_W-1:0] next_addr_s;
  logic              hit_s;
  logic              next_hit_s;
  logic              fill_done_s;
  logic              pf_go_s;

  function automatic logic [IDX_W-1:0] line_of(input logic [ADDR_W-1:0] a);
    return a[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:IDX_W];
  endfunction

  // Lookup, fill-completion and prefetch-decision terms.
  always_comb begin
    cpu_idx_s   = line_of(CPU_ADDR);
    fill_idx_s  = line_of(fetch_addr_r);
    next_addr_s = fetch_addr_r + ADDR_W'(1'b1);
    next_idx_s  = line_of(next_addr_s);
    hit_s       = (state_r == ST_IDLE) && valid_r[cpu_idx_s] &&
                  (tag_r[cpu_idx_s] == tag_of(CPU_ADDR)) && !INVALIDATE;
    next_hit_s  = valid_r[next_idx_s] && (tag_r[next_idx_s] == tag_of(next_addr_s));
    // Same-cycle ack+ready in a request state counts as a completed read.
    fill_done_s = BA_RDY && ((state_r == ST_WAIT) || (state_r == ST_PWAIT) ||
                  (((state_r == ST_REQ) || (state_r == ST_PREQ)) && BA_ACK));
    pf_go_s     = PREFETCH && ((state_r == ST_REQ) || (state_r == ST_WAIT)) &&
                  (fetch_addr_r != {ADDR_W{1'b1}}) && !next_hit_s && !INVALIDATE;
  end

  assign CPU_OK   = CPU_CS & hit_s;
  assign CPU_DOUT = data_r[cpu_idx_s];

  // Cache line storage: fill on read return, flash-clear of valid bits on invalidate.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      valid_r <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_r[i]  <= '0;
        data_r[i] <= 16'h0000;
      end
    end else begin
      if (fill_done_s && !INVALIDATE) begin
        valid_r[fill_idx_s] <= 1'b1;
        tag_r[fill_idx_s]   <= tag_of(fetch_addr_r);
        data_r[fill_idx_s]  <= DATA_READ;
      end
      if (INVALIDATE) begin
        valid_r <= '0;
      end
    end
  end

  // Request FSM with registered SDRAM request outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= ST_IDLE;
      BA_RD        <= 1'b0;
      BA_ADDR      <= 22'h000000;
      fetch_addr_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (CPU_CS && !hit_s && !INVALIDATE) begin
            fetch_addr_r <= CPU_ADDR;
            BA_RD        <= 1'b1;
            BA_ADDR      <= BANK_OFFSET + 22'(CPU_ADDR);
            state_r      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (BA_ACK) begin
            BA_RD   <= 1'b0;
            state_r <= ST_WAIT;
          end
        end
        ST_PREQ: begin
          if (BA_ACK) begin
            BA_RD   <= 1'b0;
            state_r <= ST_PWAIT;
          end
        end
        ST_WAIT, ST_PWAIT: begin
          state_r <= state_r;
        end
        default: begin
          BA_RD   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
      // Completion overrides the per-state update above (covers ack+ready together).
      if (fill_done_s) begin
        if (pf_go_s) begin
          fetch_addr_r <= next_addr_s;
          BA_RD        <= 1'b1;
          BA_ADDR      <= BANK_OFFSET + 22'(next_addr_s);
          state_r      <= ST_PREQ;
        end else begin
          state_r <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipibibs_rom_fetch.sv
// Bench for pipibibs_rom_fetch: directed cycle table, reset/offset sequences, then
// randomized traffic against a transaction-level cache model.
module tb_pipibibs_rom_fetch;

  logic        clk;
  logic        rst_n;
  logic        cpu_cs;
  logic [16:0] cpu_addr;
  logic [15:0] cpu_dout;
  logic        cpu_ok;
  logic        invalidate;
  logic [21:0] ba_addr;
  logic        ba_rd;
  logic        ba_ack;
  logic        ba_rdy;
  logic [15:0] data_read;

  logic        cs2;
  logic [16:0] addr2;
  logic [15:0] dout2;
  logic        ok2;
  logic [21:0] baddr2;
  logic        rd2;

  pipibibs_rom_fetch u_dut (
    .CLK(clk), .RESET_N(rst_n), .CPU_CS(cpu_cs), .CPU_ADDR(cpu_addr),
    .CPU_DOUT(cpu_dout), .CPU_OK(cpu_ok), .INVALIDATE(invalidate),
    .BA_ADDR(ba_addr), .BA_RD(ba_rd), .BA_ACK(ba_ack), .BA_RDY(ba_rdy),
    .DATA_READ(data_read)
  );

  pipibibs_rom_fetch #(.BANK_OFFSET(22'h100000)) u_off (
    .CLK(clk), .RESET_N(rst_n), .CPU_CS(cs2), .CPU_ADDR(addr2),
    .CPU_DOUT(dout2), .CPU_OK(ok2), .INVALIDATE(1'b0),
    .BA_ADDR(baddr2), .BA_RD(rd2), .BA_ACK(1'b0), .BA_RDY(1'b0),
    .DATA_READ(16'h0000)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        cs;
    logic [16:0] addr;
    logic        inv;
    logic        ack;
    logic        rdy;
    logic [15:0] data;
    logic        e_rd;
    logic [21:0] e_ba;
    logic        e_ok;
    logic [15:0] e_dout;
  } vec_t;

  vec_t tbl[$];

  task automatic v(input logic cs, input logic [16:0] a, input logic inv, input logic ack,
                   input logic rdy, input logic [15:0] d, input logic e_rd,
                   input logic [21:0] e_ba, input logic e_ok, input logic [15:0] e_do);
    vec_t t;
    t.cs = cs; t.addr = a; t.inv = inv; t.ack = ack; t.rdy = rdy; t.data = d;
    t.e_rd = e_rd; t.e_ba = e_ba; t.e_ok = e_ok; t.e_dout = e_do;
    tbl.push_back(t);
  endtask

  // Behavioural model state: which full address each line holds, plus the read in flight.
  bit          mvalid [8];
  logic [16:0] maddr  [8];
  int          m_phase;   // 0 none, 1 request visible, 2 accepted awaiting data
  logic [16:0] m_x;
  bit          m_pf;

  function automatic bit mhit(input logic [16:0] a);
    return mvalid[a[2:0]] && (maddr[a[2:0]] == a);
  endfunction

  function automatic logic [15:0] memf(input logic [16:0] a);
    logic [31:0] p;
    p = 32'(a) * 32'd40503;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [16:0] rnd_addr();
    logic [16:0] r;
    if ($urandom_range(0, 3) == 0) r = 17'h1FFF0 + 17'($urandom_range(0, 15));
    else r = 17'($urandom_range(0, 31));
    return r;
  endfunction

  initial begin
    bit seen_ok;
    bit exp_ok;
    bit done;
    bit pf;
    bit real_rdy;

    rst_n = 1'b0; cpu_cs = 1'b0; cpu_addr = 17'h0; invalidate = 1'b0;
    ba_ack = 1'b0; ba_rdy = 1'b0; data_read = 16'h0; cs2 = 1'b0; addr2 = 17'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rd", 32'(ba_rd), 32'h0);
    chk("reset_ba", 32'(ba_addr), 32'h0);
    chk("reset_ok", 32'(cpu_ok), 32'h0);
    chk("reset_dout", 32'(cpu_dout), 32'h0);

    // cs addr inv ack rdy data | rd ba ok dout
    v(1, 17'h10, 0, 0, 0, 16'h0,    0, 22'h0,     0, 16'h0);
    v(1, 17'h10, 0, 1, 0, 16'h0,    1, 22'h10,    0, 16'h0);
    for (int i = 0; i < 4; i++) v(1, 17'h10, 0, 0, 0, 16'h0, 0, 22'h10, 0, 16'h0);
    v(1, 17'h10, 0, 0, 1, 16'h4E71, 0, 22'h10,    0, 16'h0);
    v(1, 17'h10, 0, 1, 0, 16'h0,    1, 22'h11,    0, 16'h0);
    v(1, 17'h10, 0, 0, 1, 16'h2B3C, 0, 22'h11,    0, 16'h0);
    v(1, 17'h10, 0, 0, 0, 16'h0,    0, 22'h11,    1, 16'h4E71);
    v(0, 17'h10, 0, 0, 1, 16'hDEAD, 0, 22'h11,    0, 16'h0);
    v(1, 17'h11, 0, 0, 0, 16'h0,    0, 22'h11,    1, 16'h2B3C);
    v(1, 17'h10, 0, 0, 0, 16'h0,    0, 22'h11,    1, 16'h4E71);
    v(1, 17'h1FFFF, 0, 0, 0, 16'h0, 0, 22'h11,    0, 16'h0);
    v(1, 17'h1FFFF, 0, 1, 1, 16'hBEEF, 1, 22'h1FFFF, 0, 16'h0);
    v(1, 17'h1FFFF, 0, 0, 0, 16'h0, 0, 22'h1FFFF, 1, 16'hBEEF);
    v(0, 17'h1FFFF, 0, 0, 0, 16'h0, 0, 22'h1FFFF, 0, 16'h0);
    v(1, 17'h3,  0, 0, 0, 16'h0,    0, 22'h1FFFF, 0, 16'h0);
    v(1, 17'h3,  0, 1, 0, 16'h0,    1, 22'h3,     0, 16'h0);
    v(1, 17'h3,  0, 0, 1, 16'h1111, 0, 22'h3,     0, 16'h0);
    v(1, 17'h3,  0, 1, 1, 16'h4444, 1, 22'h4,     0, 16'h0);
    v(1, 17'h3,  0, 0, 0, 16'h0,    0, 22'h4,     1, 16'h1111);
    v(1, 17'hB,  0, 0, 0, 16'h0,    0, 22'h4,     0, 16'h0);
    v(1, 17'hB,  0, 1, 1, 16'h2222, 1, 22'hB,     0, 16'h0);
    v(1, 17'h3,  0, 1, 1, 16'hCCCC, 1, 22'hC,     0, 16'h0);
    v(1, 17'h3,  0, 0, 0, 16'h0,    0, 22'hC,     0, 16'h0);
    v(1, 17'h3,  0, 1, 0, 16'h0,    1, 22'h3,     0, 16'h0);
    v(1, 17'h3,  0, 0, 1, 16'h1111, 0, 22'h3,     0, 16'h0);
    v(1, 17'h3,  0, 1, 1, 16'h4444, 1, 22'h4,     0, 16'h0);
    v(1, 17'h3,  0, 0, 0, 16'h0,    0, 22'h4,     1, 16'h1111);
    v(1, 17'h40, 0, 0, 0, 16'h0,    0, 22'h4,     0, 16'h0);
    v(1, 17'h40, 0, 1, 0, 16'h0,    1, 22'h40,    0, 16'h0);
    v(1, 17'h40, 1, 0, 0, 16'h0,    0, 22'h40,    0, 16'h0);
    v(1, 17'h40, 1, 0, 1, 16'h7777, 0, 22'h40,    0, 16'h0);
    v(1, 17'h40, 1, 0, 0, 16'h0,    0, 22'h40,    0, 16'h0);
    v(1, 17'h40, 0, 0, 0, 16'h0,    0, 22'h40,    0, 16'h0);
    v(1, 17'h40, 0, 1, 0, 16'h0,    1, 22'h40,    0, 16'h0);
    v(1, 17'h40, 0, 0, 1, 16'h7777, 0, 22'h40,    0, 16'h0);
    v(1, 17'h40, 0, 1, 1, 16'h4141, 1, 22'h41,    0, 16'h0);
    v(1, 17'h40, 0, 0, 0, 16'h0,    0, 22'h41,    1, 16'h7777);
    v(1, 17'h3,  0, 0, 0, 16'h0,    0, 22'h41,    0, 16'h0);
    v(1, 17'h3,  0, 1, 1, 16'h1111, 1, 22'h3,     0, 16'h0);
    v(1, 17'h3,  0, 1, 1, 16'h4444, 1, 22'h4,     0, 16'h0);
    v(0, 17'h3,  0, 0, 0, 16'h0,    0, 22'h4,     0, 16'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      cpu_cs = tbl[i].cs; cpu_addr = tbl[i].addr; invalidate = tbl[i].inv;
      ba_ack = tbl[i].ack; ba_rdy = tbl[i].rdy; data_read = tbl[i].data;
      @(negedge clk);
      chk($sformatf("row%0d_rd", i), 32'(ba_rd), 32'(tbl[i].e_rd));
      chk($sformatf("row%0d_ba", i), 32'(ba_addr), 32'(tbl[i].e_ba));
      chk($sformatf("row%0d_ok", i), 32'(cpu_ok), 32'(tbl[i].e_ok));
      if (tbl[i].e_ok) chk($sformatf("row%0d_dout", i), 32'(cpu_dout), 32'(tbl[i].e_dout));
    end

    // Asynchronous reset while a request is pending.
    @(posedge clk);
    #1 cpu_cs = 1'b1; cpu_addr = 17'h50; ba_ack = 1'b0; ba_rdy = 1'b0; invalidate = 1'b0;
    @(posedge clk);
    #1 chk("midreq_rd_up", 32'(ba_rd), 32'h1);
    chk("midreq_ba", 32'(ba_addr), 32'h50);
    cpu_cs = 1'b0;
    #3 rst_n = 1'b0;
    #1 chk("async_rd_drop", 32'(ba_rd), 32'h0);
    chk("async_ba_clear", 32'(ba_addr), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      cpu_addr = 17'(i);
      #1 chk($sformatf("postrst_dout%0d", i), 32'(cpu_dout), 32'h0);
    end
    @(negedge clk);
    cpu_cs = 1'b1; cpu_addr = 17'h40;
    #1 chk("postrst_ok_40", 32'(cpu_ok), 32'h0);
    cpu_cs = 1'b0;
    cs2 = 1'b1; addr2 = 17'h5;
    @(negedge clk);
    chk("offset_rd", 32'(rd2), 32'h1);
    chk("offset_ba", 32'(baddr2), 32'h100005);
    cs2 = 1'b0;

    // Randomized traffic against the model.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin mvalid[i] = 1'b0; maddr[i] = 17'h0; end
    m_phase = 0; m_x = 17'h0; m_pf = 1'b0; seen_ok = 1'b0;
    cpu_cs = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (!cpu_cs || seen_ok) begin
        cpu_cs = ($urandom_range(0, 3) != 0);
        cpu_addr = rnd_addr();
      end else if ($urandom_range(0, 19) == 0) begin
        cpu_addr = rnd_addr();
      end
      invalidate = ($urandom_range(0, 39) == 0);
      ba_ack = (m_phase == 1) && ($urandom_range(0, 1) == 1);
      real_rdy = (m_phase == 2) || ((m_phase == 1) && ba_ack);
      if (real_rdy) ba_rdy = ($urandom_range(0, 2) == 0);
      else ba_rdy = ($urandom_range(0, 19) == 0);
      if (ba_rdy) data_read = real_rdy ? memf(m_x) : 16'($urandom);
      else data_read = 16'h0;
      @(negedge clk);
      exp_ok = cpu_cs && (m_phase == 0) && !invalidate && mhit(cpu_addr);
      chk("rnd_ok", 32'(cpu_ok), 32'(exp_ok));
      if (exp_ok) chk("rnd_dout", 32'(cpu_dout), 32'(memf(cpu_addr)));
      chk("rnd_rd", 32'(ba_rd), 32'(m_phase == 1));
      if (m_phase == 1) chk("rnd_ba", 32'(ba_addr), 32'(m_x));
      seen_ok = cpu_ok;
      done = 1'b0;
      case (m_phase)
        0: if (cpu_cs && !invalidate && !mhit(cpu_addr)) begin
             m_phase = 1; m_x = cpu_addr; m_pf = 1'b0;
           end
        1: if (ba_ack) begin
             if (ba_rdy) done = 1'b1;
             else m_phase = 2;
           end
        2: if (ba_rdy) done = 1'b1;
        default: m_phase = 0;
      endcase
      if (done) begin
        pf = !m_pf && (m_x != 17'h1FFFF) && !invalidate && !mhit(m_x + 17'd1);
        if (!invalidate) begin
          mvalid[m_x[2:0]] = 1'b1;
          maddr[m_x[2:0]] = m_x;
        end
        if (pf) begin
          m_x = m_x + 17'd1; m_pf = 1'b1; m_phase = 1;
        end else begin
          m_phase = 0;
        end
      end
      if (invalidate) for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
